attn_ram_streamer: RTL and testbench

// - Downstream consumer of the ping-pong (Q*K^T) attention score RAM group.
// - Reads one full FMAP_W x FMAP_W score buffer, in row-major order (address 0..DEPTH-1).
// - Presents the scores as a valid/ready stream to the Attn*V stage.
// - Pulses Done after the last read so the RAM group releases the bank; absorbs BRAM read latency and back-pressure.

---
 rtl/attn_ram_streamer.sv | 137 +++++++++++++
 tb/tb_attn_ram_streamer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/attn_ram_streamer.sv
// Streams one FMAP_W x FMAP_W attention score buffer out of the ping-pong RAM as a
// valid/ready stream, absorbing read latency with a credit-checked FIFO.
module attn_ram_streamer #(
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FMAP_W     = 64,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_AttnRAM_Empty,
    output logic [ADDR_W-1:0] o_AttnRam_rd_addr,
    input  logic [DATA_W-1:0] i_AttnRAM_data,
    output logic              o_AttnRam_Done,
    output logic [DATA_W-1:0] o_Attn_data,
    output logic              o_Attn_valid,
    input  logic              i_Attn_ready,
    output logic              o_Attn_last_row,
    output logic              o_Attn_last,
    output logic              o_busy
);

    localparam int unsigned DEPTH = FMAP_W * FMAP_W;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StDone, StGap} stateT;

    stateT             stateQ, stateD;
    logic [ADDR_W-1:0] rdAddrQ, rdAddrD;
    logic [RD_LAT-1:0] pipeValidQ, pipeValidD;
    logic [RD_LAT-1:0] pipeLastRowQ, pipeLastRowD;
    logic [RD_LAT-1:0] pipeLastQ, pipeLastD;

    logic [DATA_W+1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtrQ, rdPtrQ;
    logic [PTR_W:0]    fifoCountQ;
    logic [DATA_W+1:0] headEntry;

    int unsigned inflight;
    logic        earlyPending;
    logic        credit;
    logic        issue;
    logic        push;
    logic        pop;

    always_comb begin
        inflight     = 0;
        earlyPending = 1'b0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + 32'(pipeValidQ[i]);
        end
        // Reads still short of the final pipe stage keep DRAIN waiting.
        for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
            earlyPending = earlyPending | pipeValidQ[i];
        end
        credit = (32'(fifoCountQ) + inflight) < FIFO_DEPTH;

        stateD  = stateQ;
        rdAddrD = rdAddrQ;
        issue   = 1'b0;
        unique case (stateQ)
            StIdle: begin
                rdAddrD = '0;
                if (!i_AttnRAM_Empty) stateD = StRead;
            end
            StRead: begin
                if (credit) begin
                    issue = 1'b1;
                    if (rdAddrQ == LAST_ADDR) stateD = StDrain;
                    else rdAddrD = rdAddrQ + ADDR_W'(1);
                end
            end
            StDrain: if (!earlyPending) stateD = StDone;
            StDone:  stateD = StGap;
            StGap: begin
                stateD  = StIdle;
                rdAddrD = '0;
            end
            default: stateD = StIdle;
        endcase

        pipeValidD      = pipeValidQ;
        pipeLastRowD    = pipeLastRowQ;
        pipeLastD       = pipeLastQ;
        pipeValidD[0]   = issue;
        pipeLastRowD[0] = (32'(rdAddrQ) % FMAP_W) == (FMAP_W - 1);
        pipeLastD[0]    = rdAddrQ == LAST_ADDR;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipeValidD[i]   = pipeValidQ[i-1];
            pipeLastRowD[i] = pipeLastRowQ[i-1];
            pipeLastD[i]    = pipeLastQ[i-1];
        end

        push = pipeValidQ[RD_LAT-1];
        pop  = (fifoCountQ != '0) && i_Attn_ready;
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            stateQ       <= StIdle;
            rdAddrQ      <= '0;
            pipeValidQ   <= '0;
            pipeLastRowQ <= '0;
            pipeLastQ    <= '0;
            wrPtrQ       <= '0;
            rdPtrQ       <= '0;
            fifoCountQ   <= '0;
        end else begin
            stateQ       <= stateD;
            rdAddrQ      <= rdAddrD;
            pipeValidQ   <= pipeValidD;
            pipeLastRowQ <= pipeLastRowD;
            pipeLastQ    <= pipeLastD;
            if (push) wrPtrQ <= wrPtrQ + PTR_W'(1);
            if (pop) rdPtrQ <= rdPtrQ + PTR_W'(1);
            if (push && !pop) fifoCountQ <= fifoCountQ + (PTR_W+1)'(1);
            else if (!push && pop) fifoCountQ <= fifoCountQ - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; output gating hides stale entries.
    always_ff @(posedge s_clk) begin
        if (push) fifoMem[wrPtrQ] <= {pipeLastQ[RD_LAT-1], pipeLastRowQ[RD_LAT-1], i_AttnRAM_data};
    end

    assign headEntry         = fifoMem[rdPtrQ];
    assign o_Attn_valid      = fifoCountQ != '0;
    assign o_Attn_data       = o_Attn_valid ? headEntry[DATA_W-1:0] : '0;
    assign o_Attn_last_row   = o_Attn_valid & headEntry[DATA_W];
    assign o_Attn_last       = o_Attn_valid & headEntry[DATA_W+1];
    assign o_AttnRam_rd_addr = rdAddrQ;
    assign o_AttnRam_Done    = stateQ == StDone;
    assign o_busy            = stateQ != StIdle;

endmodule

// File: tb/tb_attn_ram_streamer.sv
// Directed bench for attn_ram_streamer: RD_LAT=1 instance for the main scenarios and an
// RD_LAT=2 instance for the latency/throughput check.
module tb_attn_ram_streamer;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned FMAP_W = 64;
    localparam int unsigned DEPTH  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, empty, ready, done, valid, lastRow, last, busy;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] ramData, data;
    logic              empty2, ready2, done2, valid2, lastRow2, last2, busy2;
    logic [ADDR_W-1:0] rdAddr2;
    logic [DATA_W-1:0] ramData2, ramStage2, data2;

    attn_ram_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FMAP_W(FMAP_W), .RD_LAT(1),
                        .FIFO_DEPTH(4)) dut (
        .s_clk(clk), .s_rst(rst), .i_AttnRAM_Empty(empty), .o_AttnRam_rd_addr(rdAddr),
        .i_AttnRAM_data(ramData), .o_AttnRam_Done(done), .o_Attn_data(data),
        .o_Attn_valid(valid), .i_Attn_ready(ready), .o_Attn_last_row(lastRow),
        .o_Attn_last(last), .o_busy(busy)
    );

    attn_ram_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FMAP_W(FMAP_W), .RD_LAT(2),
                        .FIFO_DEPTH(4)) dut2 (
        .s_clk(clk), .s_rst(rst), .i_AttnRAM_Empty(empty2), .o_AttnRam_rd_addr(rdAddr2),
        .i_AttnRAM_data(ramData2), .o_AttnRam_Done(done2), .o_Attn_data(data2),
        .o_Attn_valid(valid2), .i_Attn_ready(ready2), .o_Attn_last_row(lastRow2),
        .o_Attn_last(last2), .o_busy(busy2)
    );

    // RAM models with RAM[A] = A
    always @(posedge clk) ramData <= DATA_W'(rdAddr);
    always @(posedge clk) begin
        ramStage2 <= DATA_W'(rdAddr2);
        ramData2  <= ramStage2;
    end

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Streams nWords words starting at address 0 and checks order, flags, stalls and Done.
    task automatic runStream(input string tag, input int nWords, input bit randReady,
                             input bit keepEmptyLow);
        int expIdx = 0, cyc = 0, doneCnt = 0, firstValid = -1, expA;
        int doneCyc[2] = '{-1, -1};
        int lastCyc[2] = '{-2, -2};
        bit prevStall = 1'b0;
        logic [DATA_W-1:0] prevData = '0;
        empty = 1'b0;
        while (expIdx < nWords && cyc < nWords * 3 + 100) begin
            @(negedge clk);
            cyc++;
            if (!keepEmptyLow) empty = 1'b1;
            if (keepEmptyLow && doneCnt >= 1 && cyc == doneCyc[0] + 3) empty = 1'b1;
            ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prevStall) begin
                check({tag, "_stall_valid"}, 32'(valid), 1);
                check({tag, "_stall_data"}, 32'(data), 32'(prevData));
            end
            if (done) begin
                if (doneCnt < 2) doneCyc[doneCnt] = cyc;
                doneCnt++;
            end
            if (keepEmptyLow && doneCnt >= 1) begin
                if (cyc == doneCyc[0] + 1) check({tag, "_gap_addr"}, 32'(rdAddr), DEPTH - 1);
                if (cyc == doneCyc[0] + 2) begin
                    check({tag, "_restart_addr"}, 32'(rdAddr), 0);
                    check({tag, "_restart_idle"}, 32'(busy), 0);
                end
                if (cyc == doneCyc[0] + 3) check({tag, "_restart_busy"}, 32'(busy), 1);
            end
            if (valid) begin
                if (firstValid < 0) firstValid = cyc;
                expA = expIdx % DEPTH;
                check({tag, "_data"}, 32'(data), 32'(expA));
                check({tag, "_last_row"}, 32'(lastRow), 32'((expA % FMAP_W) == FMAP_W - 1));
                check({tag, "_last"}, 32'(last), 32'(expA == DEPTH - 1));
                if (expA == DEPTH - 1 && !prevStall && expIdx / DEPTH < 2)
                    lastCyc[expIdx / DEPTH] = cyc;
                if (ready) expIdx++;
            end
            prevStall = valid && !ready;
            prevData  = data;
        end
        ready = 1'b1;
        empty = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        check({tag, "_word_count"}, 32'(expIdx), 32'(nWords));
        check({tag, "_done_count"}, 32'(doneCnt), 32'(nWords / DEPTH));
        check({tag, "_idle_after"}, 32'(busy), 0);
        check({tag, "_valid_after"}, 32'(valid), 0);
        if (!randReady) begin
            check({tag, "_first_valid"}, 32'(firstValid), 3);
            check({tag, "_done_timing0"}, 32'(doneCyc[0]), 32'(lastCyc[0]));
            if (nWords > DEPTH) check({tag, "_done_timing1"}, 32'(doneCyc[1]), 32'(lastCyc[1]));
        end
    endtask

    int bad, cyc;
    bit found, sawDone;

    initial begin
        rst = 1'b1; empty = 1'b1; ready = 1'b1; empty2 = 1'b1; ready2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(rdAddr), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(data), 0);
        check("rst_flags", 32'({last, lastRow}), 0);
        check("rst_valid2", 32'(valid2), 0);
        rst = 1'b0;

        // Empty held high: nothing moves
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (rdAddr != '0 || valid || done || busy) bad++;
        end
        check("empty_hold", 32'(bad), 0);

        runStream("s1", DEPTH, 1'b0, 1'b0);
        runStream("s2", DEPTH, 1'b1, 1'b0);
        runStream("s4", 2 * DEPTH, 1'b0, 1'b1);

        // Reset mid-frame at word 1000
        empty = 1'b0;
        @(negedge clk);
        empty = 1'b1;
        found = 1'b0; sawDone = 1'b0; cyc = 0;
        while (!found && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) sawDone = 1'b1;
            if (valid && data == DATA_W'(1000)) found = 1'b1;
        end
        check("s5_reached_1000", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_addr", 32'(rdAddr), 0);
        check("s5_rst_valid", 32'(valid), 0);
        check("s5_rst_data", 32'(data), 0);
        check("s5_rst_busy", 32'(busy), 0);
        if (done) sawDone = 1'b1;
        @(negedge clk);
        if (done) sawDone = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        if (done) sawDone = 1'b1;
        check("s5_no_done", 32'(sawDone), 0);
        empty = 1'b0;
        @(negedge clk);
        empty = 1'b1;
        cyc = 0;
        while (!valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 64; k++) begin
            check("s5_restart_data", 32'(data), 32'(k));
            check("s5_restart_row", 32'(lastRow), 32'(k == 63));
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // RD_LAT=2 instance: first valid 4 cycles after Empty low, then 1 word/cycle
        empty2 = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            empty2 = 1'b1;
            check("s6_latency_invalid", 32'(valid2), 0);
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clk);
            check("s6_valid", 32'(valid2), 1);
            check("s6_data", 32'(data2), 32'(k));
            check("s6_last_row", 32'(lastRow2), 32'((k % FMAP_W) == FMAP_W - 1));
            check("s6_last", 32'(last2), 32'(k == int'(DEPTH) - 1));
            check("s6_done", 32'(done2), 32'(k == int'(DEPTH) - 1));
        end
        @(negedge clk);
        check("s6_valid_after", 32'(valid2), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
